// File: rtl/sdram_read_fifo.sv
// ============================================================================
// Module   : sdram_read_fifo
// Brief    : First-word-fall-through 32-bit FIFO between the SDRAM read engine
//            and the wishbone read path, with an early (slack) full throttle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_read_fifo #(
  parameter int DEPTH_BITS = 4,
  parameter int FULL_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [31:0]           fifo_data,
  input  logic                  fifo_wr,
  output logic                  fifo_full,
  output logic [31:0]           rd_data,
  input  logic                  rd_en,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int c_DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_DEPTH_CNT   = (DEPTH_BITS+1)'(c_DEPTH);
  localparam logic [DEPTH_BITS:0] c_FULL_THRESH = (DEPTH_BITS+1)'(c_DEPTH - FULL_SLACK);

  logic [31:0]           r_mem [0:c_DEPTH-1];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_ok;
  logic                  w_wr_ok;

  // A pop in the same cycle frees a slot, so a write at DEPTH is still taken.
  assign w_rd_ok = rd_en & (r_count != '0);
  assign w_wr_ok = fifo_wr & ((r_count < c_DEPTH_CNT) | w_rd_ok);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !clear) begin
      r_mem[r_wr_ptr] <= fifo_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
      if (fifo_wr && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign rd_data   = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign fifo_full = (r_count >= c_FULL_THRESH);
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sdram_read_fifo.sv
// ============================================================================
// Module   : tb_sdram_read_fifo
// Brief    : Scoreboard bench for sdram_read_fifo (DEPTH 16, slack 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_read_fifo;

  localparam int c_DEPTH_BITS = 4;
  localparam int c_DEPTH      = 16;
  localparam int c_THRESH     = 14;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  clear = 1'b0;
  logic [31:0]           fifo_data = '0;
  logic                  fifo_wr = 1'b0;
  logic                  fifo_full;
  logic [31:0]           rd_data;
  logic                  rd_en = 1'b0;
  logic                  empty;
  logic [c_DEPTH_BITS:0] count;
  logic                  overflow;
  logic                  underflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  sdram_read_fifo #(.DEPTH_BITS(c_DEPTH_BITS), .FULL_SLACK(2)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fifo_data(fifo_data), .fifo_wr(fifo_wr), .fifo_full(fifo_full),
    .rd_data(rd_data), .rd_en(rd_en), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One clock of stimulus: head word popped from the scoreboard before the edge,
  // occupancy outputs compared against the model after it.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
    logic rd_ok, wr_ok;
    int   exp_cnt;
    fifo_wr = wr; fifo_data = d; rd_en = rd; clear = clr;
    if (rd && !clr && sb.size() != 0) begin
      checks++;
      if (rd_data !== sb[0]) begin
        errors++;
        $display("FAIL pop_data: got %h expected %h", rd_data, sb[0]);
      end
    end
    if (clr) begin
      sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      rd_ok = rd && (sb.size() != 0);
      wr_ok = wr && ((sb.size() < c_DEPTH) || rd_ok);
      if (rd_ok) void'(sb.pop_front());
      if (wr_ok) sb.push_back(d);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_unf = 1'b1;
    end
    @(posedge clk); #1;
    fifo_wr = 1'b0; rd_en = 1'b0; clear = 1'b0;
    exp_cnt = sb.size();
    checks++;
    if (count !== (c_DEPTH_BITS+1)'(exp_cnt) || empty !== (exp_cnt == 0) ||
        fifo_full !== (exp_cnt >= c_THRESH)) begin
      errors++;
      $display("FAIL occupancy: count=%0d empty=%b full=%b expected count=%0d empty=%b full=%b",
               count, empty, fifo_full, exp_cnt, exp_cnt == 0, exp_cnt >= c_THRESH);
    end
  endtask

  task automatic check_flags(input string name);
    checks++;
    if (overflow !== m_ovf || underflow !== m_unf) begin
      errors++;
      $display("FAIL %s: overflow=%b underflow=%b expected %b %b", name, overflow, underflow, m_ovf, m_unf);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    checks++;
    if (count !== '0 || empty !== 1'b1 || fifo_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b ovf=%b unf=%b expected 0 1 0 0 0",
               count, empty, fifo_full, overflow, underflow);
    end
    for (int i = 1; i <= 3; i++) step(1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_flags("basic_flags");
  endtask

  task automatic test_full_threshold;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      if (i == 12) begin
        checks++;
        if (fifo_full !== 1'b0) begin
          errors++;
          $display("FAIL full_early: full=%b after 13 writes expected 0", fifo_full);
        end
      end
    end
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL full_rise: full=%b after 14 writes expected 1", fifo_full);
    end
    step(1'b1, 32'h1000_000E, 1'b0, 1'b0);
    step(1'b1, 32'h1000_000F, 1'b0, 1'b0);
    check_flags("full_no_ovf");
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL drop_17th: overflow=%b count=%0d expected 1 16", overflow, count);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_flags("full_drain");
  endtask

  task automatic test_underflow;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_flags("underflow_set");
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check_flags("underflow_clear");
    // Clear must win over a concurrent write and pop without raising flags.
    step(1'b1, 32'h5555_5555, 1'b1, 1'b1);
    check_flags("clear_priority");
    step(1'b1, 32'h7777_0000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h2000_0010, 1'b1, 1'b0);
    check_flags("full_rw_no_ovf");
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h3000_0001, 1'b1, 1'b0);
    check_flags("empty_rw_unf");
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    int written;
    logic rd;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    written = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h4000_0000 + 32'(written), 1'b0, 1'b0);
      written++;
    end
    for (int i = 0; written < 40 && i < 200; i++) begin
      rd = (sb.size() >= 10) ? 1'b1 : ((sb.size() <= 3) ? 1'b0 : ((i % 3) != 0));
      step(1'b1, 32'h4000_0000 + 32'(written), rd, 1'b0);
      written++;
    end
    while (sb.size() != 0) step(1'b0, 32'h0, 1'b1, 1'b0);
    check_flags("wrap_flags");
  endtask

  task automatic test_async_reset;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 32'h6000_0000 + 32'(i), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b full=%b expected 0 1 0", count, empty, fifo_full);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    step(1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
    checks++;
    if (dut.r_mem[0] !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL post_reset_slot0: mem[0]=%h expected cafe0001", dut.r_mem[0]);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #1;
    test_reset();
    test_full_threshold();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
